// File: rtl/spi_frame_master_if.sv
// spi_frame_master_if: host command/response handshake and SPI pins of the frame master.
interface spi_frame_master_if #(
    parameter int DATA_WIDTH        = 32,
    parameter int SPI_RD_ADDR_WIDTH = 4,
    parameter int SPI_WR_ADDR_WIDTH = 4
);
    logic                         cmd_valid;
    logic                         cmd_ready;
    logic [SPI_RD_ADDR_WIDTH-1:0] cmd_rd_addr;
    logic [SPI_WR_ADDR_WIDTH-1:0] cmd_wr_addr;
    logic [DATA_WIDTH-1:0]        cmd_wr_data;
    logic                         rsp_valid;
    logic [DATA_WIDTH-1:0]        rsp_rd_data;
    logic                         spi_clk;
    logic                         spi_cs_n;
    logic                         spi_mosi;
    logic                         spi_miso;

    modport master (
        input  cmd_valid, cmd_rd_addr, cmd_wr_addr, cmd_wr_data, spi_miso,
        output cmd_ready, rsp_valid, rsp_rd_data, spi_clk, spi_cs_n, spi_mosi
    );

    modport slave (
        output cmd_valid, cmd_rd_addr, cmd_wr_addr, cmd_wr_data, spi_miso,
        input  cmd_ready, rsp_valid, rsp_rd_data, spi_clk, spi_cs_n, spi_mosi
    );
endinterface

// File: rtl/spi_frame_master.sv
// spi_frame_master: SPI initiator shifting {rd_addr, wr_addr, wr_data} MSB first and capturing MISO LSB-side.
// MISO_LATE_SAMPLE_EN: sample MISO on the last clk edge of each spi_clk high phase instead of at the rise.
module spi_frame_master #(
    parameter int DATA_WIDTH        = 32,
    parameter int SPI_RD_ADDR_WIDTH = 4,
    parameter int SPI_WR_ADDR_WIDTH = 4,
    parameter int SPI_CLK_SCALE     = 1,
    parameter int CS_SETUP_CYCLES   = 1,
    parameter int CS_HOLD_CYCLES    = 1
) (
    input logic                clk,
    input logic                reset_n,
    spi_frame_master_if.master bus
);
    localparam int W       = SPI_RD_ADDR_WIDTH + SPI_WR_ADDR_WIDTH + DATA_WIDTH;
    localparam int DIV_MAX = SPI_CLK_SCALE > CS_SETUP_CYCLES
                           ? (SPI_CLK_SCALE > CS_HOLD_CYCLES ? SPI_CLK_SCALE : CS_HOLD_CYCLES)
                           : (CS_SETUP_CYCLES > CS_HOLD_CYCLES ? CS_SETUP_CYCLES : CS_HOLD_CYCLES);
    localparam int DIV_W   = $clog2(DIV_MAX + 1);
    localparam int BIT_W   = $clog2(W + 1);

    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD} state_t;

    state_t                state, state_nx;
    logic [W-1:0]          shift_reg, shift_nx;
    logic [BIT_W-1:0]      bit_cnt, bit_cnt_nx;
    logic [DIV_W-1:0]      div_cnt, div_nx, div_lim;
    logic                  div_done, miso_in;
    logic                  cmd_ready_q, spi_clk_q, spi_clk_nx, spi_cs_n_q, spi_cs_n_nx;
    logic                  rsp_valid_q, rsp_valid_nx;
    logic [DATA_WIDTH-1:0] rsp_rd_data_q, rsp_rd_data_nx;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state         <= IDLE;
            shift_reg     <= '0;
            bit_cnt       <= '0;
            div_cnt       <= '0;
            cmd_ready_q   <= 1'b1;
            spi_clk_q     <= 1'b0;
            spi_cs_n_q    <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_rd_data_q <= '0;
        end else begin
            state         <= state_nx;
            shift_reg     <= shift_nx;
            bit_cnt       <= bit_cnt_nx;
            div_cnt       <= div_nx;
            cmd_ready_q   <= state_nx == IDLE;
            spi_clk_q     <= spi_clk_nx;
            spi_cs_n_q    <= spi_cs_n_nx;
            rsp_valid_q   <= rsp_valid_nx;
            rsp_rd_data_q <= rsp_rd_data_nx;
        end

    // One divider serves every timed phase; its terminal count depends on the phase.
    always_comb begin
        div_lim        = state == SETUP ? DIV_W'(CS_SETUP_CYCLES - 1)
                       : state == HOLD  ? DIV_W'(CS_HOLD_CYCLES - 1)
                       : DIV_W'(SPI_CLK_SCALE - 1);
        div_done       = div_cnt == div_lim;
        div_nx         = (state == IDLE || div_done) ? '0 : div_cnt + 1'b1;
        state_nx       = state;
        shift_nx       = shift_reg;
        bit_cnt_nx     = bit_cnt;
        spi_clk_nx     = spi_clk_q;
        spi_cs_n_nx    = spi_cs_n_q;
        rsp_valid_nx   = 1'b0;
        rsp_rd_data_nx = rsp_rd_data_q;
        case (state)
            IDLE:
                if (bus.cmd_valid && cmd_ready_q) begin
                    shift_nx    = {bus.cmd_rd_addr, bus.cmd_wr_addr, bus.cmd_wr_data};
                    spi_cs_n_nx = 1'b0;
                    bit_cnt_nx  = '0;
                    state_nx    = SETUP;
                end
            SETUP, LOW:
                if (div_done) begin
                    spi_clk_nx = 1'b1;
                    state_nx   = HIGH;
                end
            HIGH:
                if (div_done) begin
                    spi_clk_nx = 1'b0;
                    shift_nx   = {shift_reg[W-2:0], miso_in};
                    bit_cnt_nx = bit_cnt + 1'b1;
                    state_nx   = bit_cnt == BIT_W'(W - 1) ? HOLD : LOW;
                end
            HOLD:
                if (div_done) begin
                    spi_cs_n_nx    = 1'b1;
                    rsp_valid_nx   = 1'b1;
                    rsp_rd_data_nx = shift_reg[DATA_WIDTH-1:0];
                    state_nx       = IDLE;
                end
            default: state_nx = IDLE;
        endcase
    end

`ifdef MISO_LATE_SAMPLE_EN
    assign miso_in = bus.spi_miso;
`else
    logic miso_bit;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) miso_bit <= 1'b0;
        else if (spi_clk_nx && !spi_clk_q) miso_bit <= bus.spi_miso;

    assign miso_in = miso_bit;
`endif

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rd_data = rsp_rd_data_q;
    assign bus.spi_clk     = spi_clk_q;
    assign bus.spi_cs_n    = spi_cs_n_q;
    assign bus.spi_mosi    = shift_reg[W-1];
endmodule

// File: tb/tb_spi_frame_master.sv
// tb_spi_frame_master: randomized frames against a queue-based reference of the SPI frame master.
module tb_spi_frame_master;
    localparam int DW   = 32;
    localparam int RAW  = 4;
    localparam int WAW  = 4;
    localparam int S    = 2;
    localparam int CSU  = 2;
    localparam int CSH  = 1;
    localparam int W    = RAW + WAW + DW;
    localparam int LAT  = CSU + (2 * W - 1) * S + CSH;
    localparam int LIM  = 4 * LAT;
`ifdef MISO_LATE_SAMPLE_EN
    localparam int SKEW = 1;
`else
    localparam int SKEW = 0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    spi_frame_master_if #(.DATA_WIDTH(DW), .SPI_RD_ADDR_WIDTH(RAW), .SPI_WR_ADDR_WIDTH(WAW)) bus ();

    spi_frame_master #(
        .DATA_WIDTH(DW), .SPI_RD_ADDR_WIDTH(RAW), .SPI_WR_ADDR_WIDTH(WAW),
        .SPI_CLK_SCALE(S), .CS_SETUP_CYCLES(CSU), .CS_HOLD_CYCLES(CSH)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int run = 0;
    int rises = 0;
    bit busy = 1'b0;
    bit abort = 1'b1;
    bit first = 1'b0;
    logic last_clk = 1'b0;
    logic [W-1:0] cur_resp = '0;
    logic [W-1:0] sw = '0;
    logic [W-1:0] cap = '0;
    logic [DW-1:0] last_rsp = '0;
    logic [W-1:0] fr_q[$];
    logic [W-1:0] miso_q[$];
    logic [DW-1:0] sb_q[$];
    int acc_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Reference: frame busy from accept to response, expected data and latency from queues.
    always @(negedge clk) begin
        if (!reset_n) begin
            busy = 1'b0;
            run = 0;
            last_clk = 1'b0;
        end else begin
            if (bus.rsp_valid) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: rsp_valid=1 required 0");
                end else begin
                    last_rsp = sb_q.pop_front();
                    chk("rsp_rd_data", 64'(bus.rsp_rd_data), 64'(last_rsp));
                    chk("rsp_latency", 64'(cyc - acc_q.pop_front()), 64'(LAT));
                end
                busy = 1'b0;
            end else chk("rsp_rd_data_hold", 64'(bus.rsp_rd_data), 64'(last_rsp));
            chk("cmd_ready", 64'(bus.cmd_ready), 64'(!busy));
            chk("spi_cs_n", 64'(bus.spi_cs_n), 64'(!busy));
            if (!busy) chk("spi_clk_idle", 64'(bus.spi_clk), 64'(0));
            if (bus.spi_clk != last_clk) begin
                if (first) chk("cs_setup_len", 64'(run), 64'(CSU));
                else chk("half_period", 64'(run), 64'(S));
                first = 1'b0;
                run = 1;
                last_clk = bus.spi_clk;
            end else run++;
            if (bus.cmd_valid && bus.cmd_ready) begin
                busy = 1'b1;
                first = 1'b1;
                run = 0;
                fr_q.push_back({bus.cmd_rd_addr, bus.cmd_wr_addr, bus.cmd_wr_data});
                miso_q.push_back(cur_resp);
                sb_q.push_back(cur_resp[DW-1:0]);
                acc_q.push_back(cyc + 1);
            end
        end
    end

    // Slave: launches MISO on spi_clk fall (or SKEW clks after the rise), captures MOSI on rise.
    always @(negedge bus.spi_cs_n) begin
        sw = miso_q.size() > 0 ? miso_q.pop_front() : '0;
        cap = '0;
        rises = 0;
        if (SKEW == 0) bus.spi_miso = sw[W-1];
    end

    always @(posedge bus.spi_clk) begin
        cap = {cap[W-2:0], bus.spi_mosi};
        rises++;
        if (SKEW > 0) begin
            repeat (SKEW) @(posedge clk);
            #1 bus.spi_miso = sw[W-rises];
        end
    end

    always @(negedge bus.spi_clk)
        if (SKEW == 0 && rises < W && rises > 0) bus.spi_miso = sw[W-1-rises];

    always @(posedge bus.spi_cs_n)
        if (!abort) begin
            if (fr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mosi_frame: frame seen with no command outstanding");
            end else chk("mosi_frame", 64'(cap), 64'(fr_q.pop_front()));
            chk("rise_count", 64'(rises), 64'(W));
        end

    task automatic do_reset();
        abort = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_cs_n", 64'(bus.spi_cs_n), 64'(1));
        chk("rst_spi_clk", 64'(bus.spi_clk), 64'(0));
        chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'(1));
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        chk("rst_rsp_rd_data", 64'(bus.rsp_rd_data), 64'(0));
        chk("rst_spi_mosi", 64'(bus.spi_mosi), 64'(0));
        fr_q.delete();
        miso_q.delete();
        sb_q.delete();
        acc_q.delete();
        last_rsp = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        abort = 1'b0;
    endtask

    task automatic send(input logic [RAW-1:0] rd, input logic [WAW-1:0] wr, input logic [DW-1:0] data,
                        input logic [W-1:0] resp, input bit keep);
        int n = 0;
        @(posedge clk);
        #1;
        bus.cmd_rd_addr = rd;
        bus.cmd_wr_addr = wr;
        bus.cmd_wr_data = data;
        cur_resp = resp;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        while (!bus.cmd_ready && n < LIM) begin
            @(negedge clk);
            n++;
        end
        if (n >= LIM) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: cmd_ready low for %0d cycles, required high", n);
        end
        @(posedge clk);
        #1;
        if (!keep) bus.cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((busy || sb_q.size() != 0) && n < LIM) begin
            @(negedge clk);
            n++;
        end
        if (n >= LIM) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout: %0d responses still outstanding", sb_q.size());
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [RAW-1:0] rd;
        logic [WAW-1:0] wr;
        logic [DW-1:0] data;
        logic [W-1:0] resp;
        int n;
        bus.cmd_valid = 1'b0;
        bus.cmd_rd_addr = '0;
        bus.cmd_wr_addr = '0;
        bus.cmd_wr_data = '0;
        bus.spi_miso = 1'b0;
        do_reset();
        send(4'h0, 4'h1, 32'h0000_0032, 40'h0, 1'b0);
        drain();
        send(4'h1, 4'h0, 32'h0, {8'h00, 32'hDEAD_BEEF}, 1'b0);
        drain();
        send(4'h3, 4'hC, 32'h1234_5678, {8'h5A, 32'hA5A5_A5A5}, 1'b0);
        drain();
        send(4'h7, 4'h2, 32'hCAFE_F00D, {8'hFF, 32'h0F0F_1234}, 1'b1);
        send(4'h9, 4'hE, 32'h8000_0001, {8'h01, 32'hFFFF_FFFF}, 1'b0);
        drain();
        send(4'h5, 4'h6, 32'h5555_AAAA, {8'h3C, 32'h1357_9BDF}, 1'b0);
        n = 0;
        while (rises < 20 && n < LIM) begin
            @(posedge clk);
            n++;
        end
        chk("reach_bit20", 64'(rises >= 20), 64'(1));
        do_reset();
        send(4'hA, 4'hB, 32'h0BAD_CAFE, {8'h77, 32'h2468_ACE0}, 1'b0);
        drain();
        for (int i = 0; i < 12; i++) begin
            rd = RAW'($urandom_range(0, 15));
            wr = WAW'($urandom_range(0, 15));
            data = $urandom;
            resp = {8'($urandom_range(0, 255)), 32'($urandom)};
            send(rd, wr, data, resp, i < 11 ? 1'($urandom_range(0, 1)) : 1'b0);
        end
        drain();
        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
